compare_fmt_tx: RTL and testbench
=================================

# compare_fmt_tx

Downstream formatter for the 8-bit magnitude comparator. It accepts one comparison record per handshake: operand A, operand B, and the comparator's ASCII sign byte ("=", "<" or ">"). It serialises the record as a fixed-length ASCII text line, for example "15 < 81\n", one byte per handshake on a valid/ready byte stream. The stream is intended to feed a UART transmitter or a log buffer.

## Interface
- HEX_UPPER, default 1: 1 = hex digits A–F emitted uppercase (0x41–0x46); 0 = lowercase (0x61–0x66).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  record presented on a, b, sign.
- in_ready  output  1  block can accept a record.
- a  input  8  operand A.
- b  input  8  operand B.
- sign  input  8  ASCII comparison byte from the comparator.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  8  ASCII byte of the current line.
- busy  output  1  a line is in progress (state SEND).

## Operation
- **States.** There are two states: IDLE and SEND. Internal registers: a_q, b_q, sign_q (8 bits each) and byte index idx (4 bits).
- **IDLE.**
  - in_ready=1, out_valid=0, busy=0.
  - When in_valid=1 at a clock edge, capture a, b and sign into a_q, b_q, sign_q, set idx=0, and go to SEND.
- **SEND.**
  - in_ready=0, out_valid=1, busy=1, out_data = line[idx].
  - When out_ready=1 at a clock edge:
    - If idx is the last index, go to IDLE.
    - Otherwise, idx increments.
- **Line content** (LEN=8):
  - idx 0: hex(a_q[7:4])
  - idx 1: hex(a_q[3:0])
  - idx 2: 0x20
  - idx 3: sign_q
  - idx 4: 0x20
  - idx 5: hex(b_q[7:4])
  - idx 6: hex(b_q[3:0])
  - idx 7: 0x0A
- **Hex encoding.** Nibbles 0–9 map to 0x30–0x39. Nibbles 10–15 map to "A"–"F" or "a"–"f" per HEX_UPPER.
- **Sign check.** If sign_q is not 0x3D, 0x3C or 0x3E, byte 3 is emitted as "?" (0x3F). The line length and the rest of the line are unchanged.
- **Output stability.** While out_valid=1 and out_ready=0, out_data, idx and all captured registers hold.
- **Input isolation.** Changes on a, b, sign or in_valid during SEND are ignored.
- **Reset.** rst_n low, at any time including mid-line:
  - Forces IDLE, idx=0, and a_q=b_q=sign_q=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_data=0x00.
  - The partial line is discarded. Nothing is resumed after reset.
- **out_data outside SEND.** out_data = 0x00 whenever out_valid=0.

## Timing
- **Registered outputs only.** All outputs are functions of registered state only. There is no combinational path from in_valid, a, b, sign or out_ready to any output.
- **in_ready.** in_ready = (state==IDLE). It never depends on in_valid.
- **Input-to-output latency.** If the input handshake occurs at edge N, byte 0 is valid in the cycle after edge N.
- **Streaming.** With out_ready held 1, the LEN bytes are transferred on LEN consecutive edges.
- **Return to IDLE.** After the last byte's handshake the block returns to IDLE. in_ready is high for at least one cycle before the next capture.
- **Throughput.** One record per LEN+1 cycles.
- **Input during SEND.** in_valid asserted during SEND waits. The upstream must hold the record stable until in_ready=1.
- **Backpressure.** out_ready may toggle arbitrarily. Each byte is transferred exactly once, in order, with no skips or duplicates.

## Configuration
- **COMPARE_FMT_CRLF_EN defined:**
  - LEN=9 and idx is 4 bits.
  - idx 7 = 0x0D (CR), idx 8 = 0x0A (LF).
  - Throughput is one record per 10 cycles.
- **COMPARE_FMT_CRLF_EN undefined:**
  - LEN=8 and the line ends with LF only.
- All other behaviour is identical in both builds.

## Test plan
- **Reset values.** Assert rst_n=0 for 3 cycles, then release → in_ready=1, out_valid=0, busy=0, out_data=0x00.
- **Basic line.** a=0x15, b=0x81, sign="<", out_ready=1 → 8 consecutive bytes 31 35 20 3C 20 38 31 0A. in_ready is low for exactly those 8 cycles, then high.
- **Hex case.** a=0xE0, b=0x07, sign=">":
  - HEX_UPPER=1 → 45 30 20 3E 20 30 37 0A.
  - HEX_UPPER=0 → byte 0 is 0x65.
- **Backpressure.** Same record as Basic line, with out_ready toggling in the pattern 1,0,0,1,… → identical byte sequence, out_data stable while stalled. Upstream changes a to 0xFF during SEND → the line is unaffected.
- **Invalid sign and reset.**
  - sign=0x00 → byte 3 = 0x3F.
  - Separately, rst_n pulsed low after byte 2 is transferred → immediate IDLE with out_valid=0. A new record then emits a complete, fresh line.
- **COMPARE_FMT_CRLF_EN build.** a=0x00, b=0x00, sign="=" → 30 30 20 3D 20 30 30 0D 0A. A second record accepted back-to-back starts exactly 10 cycles after the first capture.

Source files
------------

// File: rtl/compare_fmt_tx.sv
// Formats one comparator record (A, B, sign) as an ASCII text line "AA s BB\n" on a byte stream.
// Define COMPARE_FMT_CRLF_EN to end each line with CR LF instead of LF alone.
module compare_fmt_tx #(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] sign,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

`ifdef COMPARE_FMT_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t     state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] sign_q;
  logic [3:0] idx_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;
  logic [7:0] out_data_q;

  logic [3:0] idx_d;
  logic [7:0] out_data_d;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_char = 8'h30 + {4'h0, nib};
    end else if (HEX_UPPER) begin
      hex_char = 8'h37 + {4'h0, nib};
    end else begin
      hex_char = 8'h57 + {4'h0, nib};
    end
  endfunction

  // Anything other than '=', '<' or '>' is reported as '?'.
  function automatic logic [7:0] sign_char(input logic [7:0] s);
    case (s)
      8'h3D, 8'h3C, 8'h3E: sign_char = s;
      default:             sign_char = 8'h3F;
    endcase
  endfunction

  function automatic logic [7:0] line_byte(input logic [3:0] i, input logic [7:0] va,
                                           input logic [7:0] vb, input logic [7:0] vs);
    case (i)
      4'd0:    line_byte = hex_char(va[7:4]);
      4'd1:    line_byte = hex_char(va[3:0]);
      4'd2:    line_byte = 8'h20;
      4'd3:    line_byte = sign_char(vs);
      4'd4:    line_byte = 8'h20;
      4'd5:    line_byte = hex_char(vb[7:4]);
      4'd6:    line_byte = hex_char(vb[3:0]);
`ifdef COMPARE_FMT_CRLF_EN
      4'd7:    line_byte = 8'h0D;
      4'd8:    line_byte = 8'h0A;
`else
      4'd7:    line_byte = 8'h0A;
`endif
      default: line_byte = 8'h00;
    endcase
  endfunction

  // Next index and the byte it selects, so out_data can be loaded as a register.
  always_comb begin
    idx_d      = idx_q + 4'd1;
    out_data_d = line_byte(idx_d, a_q, b_q, sign_q);
  end

  // Capture/serialise state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      sign_q      <= 8'h00;
      idx_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= SEND;
            a_q         <= a;
            b_q         <= b;
            sign_q      <= sign;
            idx_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            out_data_q  <= hex_char(a[7:4]);
          end else begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= 8'h00;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q     <= IDLE;
              idx_q       <= 4'd0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              out_data_q  <= 8'h00;
            end else begin
              idx_q      <= idx_d;
              out_data_q <= out_data_d;
            end
          end else begin
            idx_q      <= idx_q;
            out_data_q <= out_data_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= 4'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          out_data_q  <= 8'h00;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_compare_fmt_tx.sv
// Directed bench for compare_fmt_tx: uppercase and lowercase instances share all stimulus.
module tb_compare_fmt_tx;

`ifdef COMPARE_FMT_CRLF_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sign;
  logic       out_ready;
  logic       in_ready,  in_ready_lc;
  logic       out_valid, out_valid_lc;
  logic [7:0] out_data,  out_data_lc;
  logic       busy,      busy_lc;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q    [0:8];
  logic [7:0] exp_lc_q [0:8];
  bit         chk_lc = 1'b0;

  compare_fmt_tx #(.HEX_UPPER(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sign(sign), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  compare_fmt_tx #(.HEX_UPPER(1'b0)) u_dut_lc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_lc),
    .a(a), .b(b), .sign(sign), .out_valid(out_valid_lc), .out_ready(out_ready),
    .out_data(out_data_lc), .busy(busy_lc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Body holds bytes 0..6; the terminator depends on the build.
  task automatic load_exp(input logic [55:0] body, input bit lc);
    for (int i = 0; i < 7; i++) begin
      if (lc) exp_lc_q[i] = body[55-8*i -: 8];
      else    exp_q[i]    = body[55-8*i -: 8];
    end
`ifdef COMPARE_FMT_CRLF_EN
    if (lc) begin exp_lc_q[7] = 8'h0D; exp_lc_q[8] = 8'h0A; end
    else    begin exp_q[7]    = 8'h0D; exp_q[8]    = 8'h0A; end
`else
    if (lc) begin exp_lc_q[7] = 8'h0A; exp_lc_q[8] = 8'h00; end
    else    begin exp_q[7]    = 8'h0A; exp_q[8]    = 8'h00; end
`endif
  endtask

  task automatic send_record(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vs);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_wait in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    a = va; b = vb; sign = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Collects n bytes; bp selects the out_ready pattern 1,0,0,1,0,0,...
  task automatic collect(input int n, input bit bp);
    int got, cyc;
    logic [7:0] held;
    bit stalled;
    got = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while (got < n && cyc < 64) begin
      out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL send_flags byte%0d valid=%b ready=%b busy=%b required 1 0 1",
                 got, out_valid, in_ready, busy);
      end
      if (stalled) begin
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL stall_hold byte%0d data=%h required %h", got, out_data, held);
        end
      end
      if (out_ready) begin
        checks++;
        if (out_data !== exp_q[got]) begin
          errors++;
          $display("FAIL line_byte%0d data=%h required %h", got, out_data, exp_q[got]);
        end
        if (chk_lc) begin
          checks++;
          if (out_data_lc !== exp_lc_q[got]) begin
            errors++;
            $display("FAIL lc_byte%0d data=%h required %h", got, out_data_lc, exp_lc_q[got]);
          end
        end
        got++;
        stalled = 1'b0;
      end else begin
        held = out_data;
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    if (got < n) begin
      errors++;
      $display("FAIL collect_timeout got=%0d required %0d", got, n);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL %s ready=%b valid=%b busy=%b data=%h required 1 0 0 00",
               tag, in_ready, out_valid, busy, out_data);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("reset_values");
  endtask

  task automatic test_basic_line;
    load_exp({8'h31, 8'h35, 8'h20, 8'h3C, 8'h20, 8'h38, 8'h31}, 1'b0);
    send_record(8'h15, 8'h81, 8'h3C);
    collect(LEN, 1'b0);
    check_idle("basic_end_idle");
  endtask

  task automatic test_hex_case;
    load_exp({8'h45, 8'h30, 8'h20, 8'h3E, 8'h20, 8'h30, 8'h37}, 1'b0);
    load_exp({8'h65, 8'h30, 8'h20, 8'h3E, 8'h20, 8'h30, 8'h37}, 1'b1);
    chk_lc = 1'b1;
    send_record(8'hE0, 8'h07, 8'h3E);
    collect(LEN, 1'b0);
    chk_lc = 1'b0;
    check_idle("hex_end_idle");
  endtask

  task automatic test_backpressure;
    load_exp({8'h31, 8'h35, 8'h20, 8'h3C, 8'h20, 8'h38, 8'h31}, 1'b0);
    send_record(8'h15, 8'h81, 8'h3C);
    a = 8'hFF;
    b = 8'h00;
    collect(LEN, 1'b1);
    check_idle("bp_end_idle");
  endtask

  task automatic test_invalid_sign;
    load_exp({8'h41, 8'h42, 8'h20, 8'h3F, 8'h20, 8'h43, 8'h44}, 1'b0);
    send_record(8'hAB, 8'hCD, 8'h00);
    collect(LEN, 1'b0);
    check_idle("badsign_end_idle");
  endtask

  task automatic test_reset_midline;
    load_exp({8'h39, 8'h38, 8'h20, 8'h3E, 8'h20, 8'h31, 8'h32}, 1'b0);
    send_record(8'h98, 8'h12, 8'h3E);
    collect(3, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midline_reset ready=%b valid=%b busy=%b data=%h required 1 0 0 00",
               in_ready, out_valid, busy, out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    load_exp({8'h30, 8'h37, 8'h20, 8'h3D, 8'h20, 8'h37, 8'h30}, 1'b0);
    send_record(8'h07, 8'h70, 8'h3D);
    collect(LEN, 1'b0);
    check_idle("fresh_end_idle");
  endtask

  task automatic test_back_to_back;
    int k;
    bit prev_busy;
    load_exp({8'h30, 8'h30, 8'h20, 8'h3D, 8'h20, 8'h30, 8'h30}, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    a = 8'h00; b = 8'h00; sign = 8'h3D; in_valid = 1'b1;
    @(posedge clk); #1;
    collect(LEN, 1'b0);
    // After the last byte, one IDLE cycle, then the held record is captured again.
    k = LEN;
    prev_busy = busy;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (!prev_busy && busy) break;
      prev_busy = busy;
    end
    in_valid = 1'b0;
    checks++;
    if (k !== LEN + 1) begin
      errors++;
      $display("FAIL b2b_spacing cycles=%0d required %0d", k, LEN + 1);
    end
    collect(LEN, 1'b0);
    check_idle("b2b_end_idle");
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; sign = 8'h00; out_ready = 1'b1;
    test_reset();
    test_basic_line();
    test_hex_case();
    test_backpressure();
    test_invalid_sign();
    test_reset_midline();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
